// File: rtl/rv32i_dmem_responder.sv
// Data-memory responder for an RV32I core: byte-masked word RAM plus a CLINT-style
// register window (msip, mtimecmp, mtime shadows) with registered load data and pulses.
module rv32i_dmem_responder #(
  parameter logic [31:0] RAM_BASE        = 32'h0000_1000,
  parameter int unsigned RAM_DEPTH_WORDS = 1024,
  parameter logic [31:0] CLINT_BASE      = 32'h8000_0000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_daddr,
  input  logic [31:0] i_dout,
  input  logic [3:0]  i_wr_mask,
  input  logic        i_wr_en,
  output logic [31:0] o_din,
  output logic        o_software_interrupt,
  output logic        o_mtime_wr,
  output logic [63:0] o_mtime_din,
  output logic        o_mtimecmp_wr,
  output logic [63:0] o_mtimecmp_din,
  output logic        o_bus_err
);

  localparam int unsigned AW = $clog2(RAM_DEPTH_WORDS);

  // CLINT word offsets (byte offset >> 2) within the 64 KiB window
  localparam logic [13:0] OFF_MSIP        = 14'h0000;
  localparam logic [13:0] OFF_MTIMECMP_LO = 14'h1000;
  localparam logic [13:0] OFF_MTIMECMP_HI = 14'h1001;
  localparam logic [13:0] OFF_MTIME_LO    = 14'h2FFE;
  localparam logic [13:0] OFF_MTIME_HI    = 14'h2FFF;

  // Byte lanes are carried by the mask, so the low address bits play no part in decode.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^i_daddr[1:0];

  // ------------------------------------------------------------------
  // Address decode
  // ------------------------------------------------------------------
  logic          ram_hit;
  logic          clint_hit;
  logic [13:0]   clint_off;
  logic [AW-1:0] ram_idx;
  logic          msip_hit;
  logic          cmp_lo_hit;
  logic          cmp_hi_hit;
  logic          mtime_lo_hit;
  logic          mtime_hi_hit;
  logic          mapped;

  assign ram_hit   = (i_daddr[31:AW+2] == RAM_BASE[31:AW+2]);
  assign ram_idx   = i_daddr[AW+1:2];
  assign clint_hit = (i_daddr[31:16] == CLINT_BASE[31:16]);
  assign clint_off = i_daddr[15:2];

  assign msip_hit     = clint_hit && (clint_off == OFF_MSIP);
  assign cmp_lo_hit   = clint_hit && (clint_off == OFF_MTIMECMP_LO);
  assign cmp_hi_hit   = clint_hit && (clint_off == OFF_MTIMECMP_HI);
  assign mtime_lo_hit = clint_hit && (clint_off == OFF_MTIME_LO);
  assign mtime_hi_hit = clint_hit && (clint_off == OFF_MTIME_HI);

  assign mapped = ram_hit | msip_hit | cmp_lo_hit | cmp_hi_hit | mtime_lo_hit | mtime_hi_hit;

  logic wr_act;
  assign wr_act = i_wr_en && !i_rst;

  function automatic logic [31:0] merge_lanes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  mask);
    logic [31:0] res;
    res = old_word;
    for (int b = 0; b < 4; b++) begin
      if (mask[b]) res[8*b +: 8] = new_word[8*b +: 8];
    end
    return res;
  endfunction

  // ------------------------------------------------------------------
  // Data RAM: read-before-write, no reset on the array
  // ------------------------------------------------------------------
  logic [31:0] mem [RAM_DEPTH_WORDS];
  logic [31:0] ram_rd_q;
  logic        sel_ram_q;

  always_ff @(posedge i_clk) begin
    if (wr_act && ram_hit) begin
      for (int b = 0; b < 4; b++) begin
        if (i_wr_mask[b]) mem[ram_idx][8*b +: 8] <= i_dout[8*b +: 8];
      end
    end
    ram_rd_q <= mem[ram_idx];
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) sel_ram_q <= 1'b0;
    else       sel_ram_q <= ram_hit;
  end

  // ------------------------------------------------------------------
  // CLINT shadows
  // ------------------------------------------------------------------
  logic        msip_q;
  logic [63:0] mtimecmp_q;
  logic [63:0] mtime_q;
  logic        msip_d;
  logic [63:0] mtimecmp_d;
  logic [63:0] mtime_d;

  always_comb begin
    msip_d     = msip_q;
    mtimecmp_d = mtimecmp_q;
    mtime_d    = mtime_q;
    if (wr_act) begin
      if (msip_hit && i_wr_mask[0]) msip_d = i_dout[0];
      if (cmp_lo_hit)   mtimecmp_d[31:0]  = merge_lanes(mtimecmp_q[31:0],  i_dout, i_wr_mask);
      if (cmp_hi_hit)   mtimecmp_d[63:32] = merge_lanes(mtimecmp_q[63:32], i_dout, i_wr_mask);
      if (mtime_lo_hit) mtime_d[31:0]     = merge_lanes(mtime_q[31:0],     i_dout, i_wr_mask);
      if (mtime_hi_hit) mtime_d[63:32]    = merge_lanes(mtime_q[63:32],    i_dout, i_wr_mask);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      msip_q     <= 1'b0;
      mtimecmp_q <= 64'hFFFF_FFFF_FFFF_FFFF;
      mtime_q    <= 64'h0;
    end else begin
      msip_q     <= msip_d;
      mtimecmp_q <= mtimecmp_d;
      mtime_q    <= mtime_d;
    end
  end

  // ------------------------------------------------------------------
  // Register read path (old values: read-before-write)
  // ------------------------------------------------------------------
  logic [31:0] reg_rd_d;
  logic [31:0] reg_rd_q;

  always_comb begin
    reg_rd_d = 32'h0;
    if (msip_hit)          reg_rd_d = {31'b0, msip_q};
    else if (cmp_lo_hit)   reg_rd_d = mtimecmp_q[31:0];
    else if (cmp_hi_hit)   reg_rd_d = mtimecmp_q[63:32];
    else if (mtime_lo_hit) reg_rd_d = mtime_q[31:0];
    else if (mtime_hi_hit) reg_rd_d = mtime_q[63:32];
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) reg_rd_q <= 32'h0;
    else       reg_rd_q <= reg_rd_d;
  end

  assign o_din = sel_ram_q ? ram_rd_q : reg_rd_q;

  // ------------------------------------------------------------------
  // Pulses
  // ------------------------------------------------------------------
  logic was_rst_q;
  logic mtimecmp_wr_q;
  logic mtime_wr_q;
  logic bus_err_q;

  // was_rst_q forces one all-ones mtimecmp load on the first cycle out of reset
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      was_rst_q     <= 1'b1;
      mtimecmp_wr_q <= 1'b0;
      mtime_wr_q    <= 1'b0;
      bus_err_q     <= 1'b0;
    end else begin
      was_rst_q     <= 1'b0;
      mtimecmp_wr_q <= was_rst_q | (i_wr_en & (cmp_lo_hit | cmp_hi_hit));
      mtime_wr_q    <= i_wr_en & (mtime_lo_hit | mtime_hi_hit);
      bus_err_q     <= i_wr_en & ~mapped;
    end
  end

  assign o_software_interrupt = msip_q;
  assign o_mtimecmp_wr        = mtimecmp_wr_q;
  assign o_mtimecmp_din       = mtimecmp_q;
  assign o_mtime_wr           = mtime_wr_q;
  assign o_mtime_din          = mtime_q;
  assign o_bus_err            = bus_err_q;

endmodule

// File: tb/tb_rv32i_dmem_responder.sv
// Directed self-checking bench for rv32i_dmem_responder: RAM lanes, read-before-write,
// CLINT shadows and pulses, bus errors and reset behaviour.
module tb_rv32i_dmem_responder;

  logic        clk;
  logic        rst;
  logic [31:0] daddr;
  logic [31:0] dout;
  logic [3:0]  wr_mask;
  logic        wr_en;
  logic [31:0] din;
  logic        sw_int;
  logic        mtime_wr;
  logic [63:0] mtime_din;
  logic        mtimecmp_wr;
  logic [63:0] mtimecmp_din;
  logic        bus_err;

  int checks = 0;
  int errors = 0;

  rv32i_dmem_responder dut (
    .i_clk                (clk),
    .i_rst                (rst),
    .i_daddr              (daddr),
    .i_dout               (dout),
    .i_wr_mask            (wr_mask),
    .i_wr_en              (wr_en),
    .o_din                (din),
    .o_software_interrupt (sw_int),
    .o_mtime_wr           (mtime_wr),
    .o_mtime_din          (mtime_din),
    .o_mtimecmp_wr        (mtimecmp_wr),
    .o_mtimecmp_din       (mtimecmp_din),
    .o_bus_err            (bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] m);
    wr_en   = we;
    daddr   = a;
    dout    = d;
    wr_mask = m;
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 4'h0);
    tick();
    tick();
    chk("rst_din", din, 0);
    chk("rst_msip", sw_int, 0);
    chk("rst_cmp_wr", mtimecmp_wr, 0);
    chk("rst_mtime_wr", mtime_wr, 0);
    chk("rst_bus_err", bus_err, 0);
    chk("rst_cmp_din", mtimecmp_din, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("rst_mtime_din", mtime_din, 0);

    // Reset release: one all-ones mtimecmp pulse
    rst = 1'b0;
    tick();
    chk("post_rst_cmp_wr", mtimecmp_wr, 1);
    chk("post_rst_cmp_din", mtimecmp_din, 64'hFFFF_FFFF_FFFF_FFFF);
    tick();
    chk("post_rst_cmp_wr_drop", mtimecmp_wr, 0);

    // RAM byte lanes
    drive(1'b1, 32'h0000_1004, 32'hDEAD_BEEF, 4'b1111);
    tick();
    drive(1'b1, 32'h0000_1004, 32'h0000_5500, 4'b0010);
    tick();
    drive(1'b0, 32'h0000_1004, 32'h0, 4'h0);
    tick();
    chk("ram_lane_merge", din, 32'hDEAD_55EF);
    chk("ram_no_bus_err", bus_err, 0);

    // Read-before-write on the same word
    drive(1'b1, 32'h0000_1008, 32'h0, 4'b1111);
    tick();
    drive(1'b1, 32'h0000_1008, 32'h1111_1111, 4'b1111);
    tick();
    chk("rbw_old", din, 32'h0);
    drive(1'b0, 32'h0000_1008, 32'h0, 4'h0);
    tick();
    chk("rbw_new", din, 32'h1111_1111);

    // MSIP
    drive(1'b1, 32'h8000_0000, 32'h1, 4'b0001);
    tick();
    chk("msip_set", sw_int, 1);
    drive(1'b0, 32'h8000_0000, 32'h0, 4'h0);
    tick();
    chk("msip_read", din, 1);
    drive(1'b1, 32'h8000_0000, 32'h0, 4'b0001);
    tick();
    chk("msip_clr", sw_int, 0);

    // MTIMECMP: back-to-back pulses
    drive(1'b1, 32'h8000_4000, 32'h10, 4'b1111);
    tick();
    chk("cmp_lo_wr", mtimecmp_wr, 1);
    chk("cmp_lo_din", mtimecmp_din, 64'hFFFF_FFFF_0000_0010);
    drive(1'b1, 32'h8000_4004, 32'h0, 4'b1111);
    tick();
    chk("cmp_hi_wr", mtimecmp_wr, 1);
    chk("cmp_hi_din", mtimecmp_din, 64'h0000_0000_0000_0010);
    drive(1'b0, 32'h8000_4000, 32'h0, 4'h0);
    tick();
    chk("cmp_wr_drop", mtimecmp_wr, 0);
    chk("cmp_din_hold", mtimecmp_din, 64'h0000_0000_0000_0010);
    chk("cmp_lo_read", din, 32'h10);

    // MTIME
    drive(1'b1, 32'h8000_BFF8, 32'h5, 4'b1111);
    tick();
    chk("mtime_wr", mtime_wr, 1);
    chk("mtime_din", mtime_din, 64'h5);
    chk("mtime_no_cmp_wr", mtimecmp_wr, 0);
    drive(1'b0, 32'h8000_BFF8, 32'h0, 4'h0);
    tick();
    chk("mtime_wr_drop", mtime_wr, 0);
    chk("mtime_read", din, 32'h5);

    // Zero mask still pulses but leaves the shadow alone
    drive(1'b1, 32'h8000_BFFC, 32'hFFFF_FFFF, 4'b0000);
    tick();
    chk("mask0_pulse", mtime_wr, 1);
    chk("mask0_din", mtime_din, 64'h5);

    // Unmapped store and load; then reset kills the pulse
    drive(1'b1, 32'h4000_0000, 32'h1234_5678, 4'b1111);
    tick();
    chk("bus_err", bus_err, 1);
    chk("unmapped_read", din, 0);
    chk("unmapped_no_mtime_wr", mtime_wr, 0);
    drive(1'b1, 32'h8000_0000, 32'h1, 4'b1111);
    rst = 1'b1;
    tick();
    chk("rst_kills_bus_err", bus_err, 0);
    chk("rst_store_ignored", sw_int, 0);
    chk("rst_cmp_restore", mtimecmp_din, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("rst_mtime_clear", mtime_din, 0);

    // Release with a store landing on the post-reset pulse cycle
    rst = 1'b0;
    drive(1'b0, 32'h0000_1004, 32'h0, 4'h0);
    tick();
    chk("rel_cmp_wr", mtimecmp_wr, 1);
    chk("ram_kept", din, 32'hDEAD_55EF);
    drive(1'b1, 32'h8000_4000, 32'h20, 4'b1111);
    tick();
    chk("rel_b2b_wr", mtimecmp_wr, 1);
    chk("rel_b2b_din", mtimecmp_din, 64'hFFFF_FFFF_0000_0020);
    drive(1'b0, 32'h0, 32'h0, 4'h0);
    tick();
    chk("rel_wr_drop", mtimecmp_wr, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
